mux_scan: RTL and testbench

//  Parametrised N-channel, WIDTH-bit multiplexer with a registered output and a valid/ready handshake.

---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/mux_scan_sel.sv | 23 ++
 rtl/mux_scan.sv | 161 ++++++++++++++++
 tb/tb_mux_scan.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared definitions for mux_scan: FSM state encodings and settle-counter width.
// Imported by the RTL and by the bench.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam int DWELL_W = 8;

endpackage

// File: rtl/mux_scan_sel.sv
// Purpose: combinational N:1 WIDTH-bit channel selector; index >= N yields zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module mux_scan_sel #(
    parameter int N     = 16,
    parameter int WIDTH = 1,
    parameter int SEL_W = 4
) (
    input  logic [N*WIDTH-1:0] bus,
    input  logic [SEL_W-1:0]   idx,
    output logic [WIDTH-1:0]   dat
);

    always_comb begin
        dat = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SEL_W'(k)) begin
                dat = bus[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Purpose: N-channel mux with registered output; manual select or DWELL-settled ascending sweep.
// Latency: 1 cycle from capture decision to out_valid; optional MUX_SCAN_MASK_EN adds scan_mask.
// Backpressure: captures only when the output slot is free; the sweep never advances without a capture.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int N     = 16,
    parameter  int DWELL = 0,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               start,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]       scan_mask,
`endif
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [DWELL_W-1:0] DWELL_V = DWELL_W'(DWELL);
    localparam state_t ST_ENTRY = (DWELL == 0) ? ST_CAPTURE : ST_SETTLE;

    state_t               state;
    logic [SEL_W-1:0]     ch;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [SEL_W-1:0]     mux_idx;
    logic [WIDTH-1:0]     mux_dat;
    logic                 slot_free;
    logic                 cap;
    logic [N-1:0]         start_mask;
    logic [N-1:0]         sweep_mask;
    logic [SEL_W:0]       first_hit;
    logic [SEL_W:0]       next_hit;

`ifdef MUX_SCAN_MASK_EN
    logic [N-1:0] mask_q;

    // The mask is frozen at start so mid-sweep changes cannot reorder or skip channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (state == ST_IDLE && mode && start) begin
            mask_q <= scan_mask;
        end
    end

    assign start_mask = scan_mask;
    assign sweep_mask = mask_q;
`else
    assign start_mask = '1;
    assign sweep_mask = '1;
`endif

    // {found, index} of the lowest enabled channel above cur (or at cur when incl).
    function automatic logic [SEL_W:0] find_en(input logic [N-1:0]     m,
                                               input logic [SEL_W-1:0] cur,
                                               input logic             incl);
        logic [SEL_W:0] hit;
        hit = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (m[k] && (k > int'(cur) || (incl && k == int'(cur)))) begin
                hit = {1'b1, SEL_W'(k)};
            end
        end
        return hit;
    endfunction

    assign first_hit = find_en(start_mask, '0, 1'b1);
    assign next_hit  = find_en(sweep_mask, ch, 1'b0);
    assign slot_free = !out_valid || out_ready;
    assign mux_idx   = (state == ST_IDLE) ? sel : ch;

    mux_scan_sel #(
        .N     (N),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_sel (
        .bus (in_bus),
        .idx (mux_idx),
        .dat (mux_dat)
    );

    always_comb begin
        cap = 1'b0;
        case (state)
            ST_IDLE:    cap = !mode && slot_free;
            ST_CAPTURE: cap = slot_free;
            default:    cap = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ch        <= '0;
            dwell_cnt <= '0;
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (cap) begin
                out_data  <= mux_dat;
                out_sel   <= mux_idx;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (mode && start) begin
                        if (first_hit[SEL_W]) begin
                            ch        <= first_hit[SEL_W-1:0];
                            dwell_cnt <= DWELL_V;
                            busy      <= 1'b1;
                            state     <= ST_ENTRY;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (dwell_cnt == DWELL_W'(1)) begin
                        dwell_cnt <= '0;
                        state     <= ST_CAPTURE;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (slot_free) begin
                        if (next_hit[SEL_W]) begin
                            ch        <= next_hit[SEL_W-1:0];
                            dwell_cnt <= DWELL_V;
                            state     <= ST_ENTRY;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: two instances (N=16/W=1/DWELL=2 and N=5/W=4/DWELL=1) against a behavioural model.
module tb_mux_scan;

    logic        clk;
    logic        rst_n;

    logic [15:0] a_bus;
    logic        a_mode, a_start, a_ready;
    logic [3:0]  a_sel;
    logic [0:0]  a_data;
    logic [3:0]  a_osel;
    logic        a_valid, a_busy, a_done;

    logic [19:0] b_bus;
    logic        b_mode, b_start, b_ready;
    logic [2:0]  b_sel;
    logic [3:0]  b_data;
    logic [2:0]  b_osel;
    logic        b_valid, b_busy, b_done;

`ifdef MUX_SCAN_MASK_EN
    logic [15:0] a_mask;
    logic [4:0]  b_mask;
    function automatic int a_mask_i(); return int'(a_mask); endfunction
    function automatic int b_mask_i(); return int'(b_mask); endfunction
`else
    function automatic int a_mask_i(); return 'hFFFF; endfunction
    function automatic int b_mask_i(); return 'h1F; endfunction
`endif

    mux_scan #(.WIDTH(1), .N(16), .DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(a_bus), .mode(a_mode), .sel(a_sel), .start(a_start),
`ifdef MUX_SCAN_MASK_EN
        .scan_mask(a_mask),
`endif
        .out_data(a_data), .out_sel(a_osel), .out_valid(a_valid), .out_ready(a_ready),
        .busy(a_busy), .done(a_done)
    );

    mux_scan #(.WIDTH(4), .N(5), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(b_bus), .mode(b_mode), .sel(b_sel), .start(b_start),
`ifdef MUX_SCAN_MASK_EN
        .scan_mask(b_mask),
`endif
        .out_data(b_data), .out_sel(b_osel), .out_valid(b_valid), .out_ready(b_ready),
        .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: outstanding sweep channels kept as a bit set, settle as a countdown.
    typedef struct {
        bit valid;
        int data;
        int sel;
        bit busy;
        bit done;
        int settle;
        int rem;
    } mdl_t;

    function automatic mdl_t step(input mdl_t m, input int n, input int dwell, input int width,
                                  input logic [63:0] bus, input logic mode, input int sel,
                                  input logic start, input logic ready, input int mask);
        mdl_t r;
        int   ch;
        bit   cap;
        bit   free;
        r      = m;
        r.done = 0;
        cap    = 0;
        ch     = 0;
        free   = !m.valid || ready;
        if (!m.busy) begin
            if (!mode) begin
                cap = free;
                ch  = sel;
            end else if (start) begin
                r.rem = mask & ((1 << n) - 1);
                if (r.rem == 0) r.done = 1;
                else begin
                    r.busy   = 1;
                    r.settle = dwell;
                end
            end
        end else if (m.settle > 0) begin
            r.settle = m.settle - 1;
        end else if (free) begin
            while (((m.rem >> ch) & 1) == 0) ch++;
            cap   = 1;
            r.rem = m.rem & ~(1 << ch);
            if (r.rem == 0) begin
                r.busy = 0;
                r.done = 1;
            end else begin
                r.settle = dwell;
            end
        end
        if (cap) begin
            r.valid = 1;
            r.sel   = ch;
            r.data  = (ch < n) ? int'((bus >> (ch * width)) & ((64'd1 << width) - 1)) : 0;
        end else if (m.valid && ready) begin
            r.valid = 0;
        end
        return r;
    endfunction

    mdl_t ma, mb;
    int   cyc = 0;

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ma = '{default: 0};
                mb = '{default: 0};
            end else begin
                cyc++;
                ma = step(ma, 16, 2, 1, 64'(a_bus), a_mode, int'(a_sel), a_start, a_ready, a_mask_i());
                mb = step(mb, 5, 1, 4, 64'(b_bus), b_mode, int'(b_sel), b_start, b_ready, b_mask_i());
            end
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            chk("a_valid", 64'(a_valid), 64'(ma.valid));
            chk("a_data",  64'(a_data),  64'(ma.data));
            chk("a_sel",   64'(a_osel),  64'(ma.sel));
            chk("a_busy",  64'(a_busy),  64'(ma.busy));
            chk("a_done",  64'(a_done),  64'(ma.done));
            chk("b_valid", 64'(b_valid), 64'(mb.valid));
            chk("b_data",  64'(b_data),  64'(mb.data));
            chk("b_sel",   64'(b_osel),  64'(mb.sel));
            chk("b_busy",  64'(b_busy),  64'(mb.busy));
            chk("b_done",  64'(b_done),  64'(mb.done));
        end
    end

    // Transfer log for dut_a, sampled after the stimulus has settled for the coming edge.
    int acc_q[$];
    int vcyc[$];
    int done_cnt      = 0;
    int last_done_cyc = 0;

    initial forever begin
        @(negedge clk);
        #2;
        if (a_valid === 1'b1) vcyc.push_back(cyc);
        if (a_valid === 1'b1 && a_ready === 1'b1) acc_q.push_back(int'(a_osel));
        if (a_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        nxt();
        a_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int i;
        i = 0;
        while (done_cnt == d0 && i < 400) begin
            nxt();
            i++;
        end
        chk({nm, "_done_seen"}, 64'(done_cnt > d0), 64'd1);
    endtask

    task automatic wait_sel(input int s, input string nm);
        int i;
        i = 0;
        while (!(a_valid === 1'b1 && int'(a_osel) == s) && i < 400) begin
            nxt();
            i++;
        end
        chk({nm, "_sel_reached"}, 64'(a_osel), 64'(s));
    endtask

    task automatic check_seq(input int base, input int cnt, input int stride, input string nm);
        chk({nm, "_count"}, 64'(acc_q.size() - base), 64'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (base + i < acc_q.size()) chk({nm, "_order"}, 64'(acc_q[base + i]), 64'(i * stride));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, v0, d0, s0, unstable;
        logic [0:0]  hd;
        logic [3:0]  hs;
        logic [15:0] pat;

        rst_n = 1'b0;
        a_bus = '0; a_mode = 0; a_sel = '0; a_start = 0; a_ready = 0;
        b_bus = '0; b_mode = 0; b_sel = '0; b_start = 0; b_ready = 0;
`ifdef MUX_SCAN_MASK_EN
        a_mask = '1;
        b_mask = '1;
`endif
        nxt();
        nxt();
        chk("rst_a_valid", 64'(a_valid), 64'd0);
        chk("rst_a_busy",  64'(a_busy),  64'd0);
        chk("rst_a_done",  64'(a_done),  64'd0);
        chk("rst_a_data",  64'(a_data),  64'd0);
        chk("rst_a_sel",   64'(a_osel),  64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        rst_n   = 1'b1;
        b_ready = 1'b1;
        b_bus   = 20'hEDCBA;

        // Manual mode, every channel of a fixed pattern.
        pat     = 16'hA5C3;
        a_bus   = pat;
        a_ready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            a_sel = 4'(s);
            nxt();
            chk("man_data", 64'(a_data), 64'(pat[s]));
            chk("man_sel",  64'(a_osel), 64'(s));
            case (s)
                0:  chk("man_pin0",  64'(a_data), 64'd1);
                2:  chk("man_pin2",  64'(a_data), 64'd0);
                13: chk("man_pin13", 64'(a_data), 64'd1);
                default: ;
            endcase
        end

        // Full sweep with ready high: DWELL=2 spacing and done alignment.
        a_mode = 1'b1;
        a_bus  = 16'h3C5A;
        nxt();
        nxt();
        b0 = acc_q.size();
        v0 = vcyc.size();
        d0 = done_cnt;
        start_a();
        s0 = cyc;
        chk("scan_busy_after_start", 64'(a_busy), 64'd1);
        wait_done(d0, "scan");
        check_seq(b0, 16, 1, "scan");
        chk("scan_ncycles", 64'(vcyc.size() - v0), 64'd16);
        if (vcyc.size() >= v0 + 16) begin
            chk("scan_first_latency", 64'(vcyc[v0] - s0), 64'd3);
            for (int i = 0; i < 15; i++)
                chk("scan_spacing", 64'(vcyc[v0 + i + 1] - vcyc[v0 + i]), 64'd3);
            chk("scan_done_cycle", 64'(last_done_cyc), 64'(vcyc[v0 + 15]));
        end
        chk("scan_done_count", 64'(done_cnt - d0), 64'd1);

        // Backpressure: stall 10 cycles on channel 5.
        nxt();
        b0 = acc_q.size();
        d0 = done_cnt;
        start_a();
        wait_sel(5, "bp");
        a_ready  = 1'b0;
        hd       = a_data;
        hs       = a_osel;
        unstable = 0;
        repeat (10) begin
            nxt();
            if (a_valid !== 1'b1 || a_data !== hd || a_osel !== hs) unstable++;
        end
        chk("bp_stable_cycles", 64'(unstable), 64'd0);
        chk("bp_held_sel", 64'(a_osel), 64'd5);
        a_ready = 1'b1;
        wait_done(d0, "bp");
        check_seq(b0, 16, 1, "bp");

        // Reset mid-sweep on channel 6.
        a_bus = 16'hFFFF;
        nxt();
        d0 = done_cnt;
        start_a();
        wait_sel(6, "rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(a_valid), 64'd0);
        chk("rst_mid_busy",  64'(a_busy),  64'd0);
        chk("rst_mid_data",  64'(a_data),  64'd0);
        chk("rst_mid_sel",   64'(a_osel),  64'd0);
        repeat (3) nxt();
        rst_n = 1'b1;
        repeat (4) nxt();
        chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_mid_idle",    64'(a_busy),        64'd0);

        // N=5: out-of-range select and start ignored in manual mode.
        b_mode = 1'b0;
        b_sel  = 3'd7;
        nxt();
        chk("n5_sel7_data", 64'(b_data), 64'd0);
        chk("n5_sel7_sel",  64'(b_osel), 64'd7);
        b_sel = 3'd3;
        nxt();
        chk("n5_sel3_data", 64'(b_data), 64'hD);
        b_start = 1'b1;
        nxt();
        b_start = 1'b0;
        chk("n5_start_mode0_busy", 64'(b_busy), 64'd0);
        nxt();
        chk("n5_start_mode0_busy2", 64'(b_busy), 64'd0);
        chk("n5_start_mode0_done",  64'(b_done), 64'd0);

`ifdef MUX_SCAN_MASK_EN
        a_mask = 16'h8421;
        nxt();
        b0 = acc_q.size();
        d0 = done_cnt;
        start_a();
        a_mask = 16'hFFFF;
        wait_done(d0, "mask");
        check_seq(b0, 4, 5, "mask");
        nxt();
        nxt();
        a_mask = 16'h0000;
        a_start = 1'b1;
        nxt();
        a_start = 1'b0;
        chk("mask0_done",  64'(a_done),  64'd1);
        chk("mask0_busy",  64'(a_busy),  64'd0);
        chk("mask0_valid", 64'(a_valid), 64'd0);
        nxt();
        chk("mask0_valid_after", 64'(a_valid), 64'd0);
        chk("mask0_done_once",   64'(a_done),  64'd0);
`endif

        // Randomised traffic on both instances, checked every cycle by the model.
        for (int i = 0; i < 2000; i++) begin
            nxt();
            a_bus   = 16'($urandom);
            b_bus   = 20'($urandom);
            a_mode  = ($urandom_range(0, 3) != 0);
            b_mode  = ($urandom_range(0, 3) != 0);
            a_sel   = 4'($urandom_range(0, 15));
            b_sel   = 3'($urandom_range(0, 7));
            a_start = ($urandom_range(0, 4) == 0);
            b_start = ($urandom_range(0, 4) == 0);
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_SCAN_MASK_EN
            a_mask  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            b_mask  = ($urandom_range(0, 7) == 0) ? 5'h0 : 5'($urandom);
`endif
        end
        nxt();
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
